// File: rtl/lane_vrf_write_port.sv
// lane_vrf_write_port: stage-3 VRF write receiver with a single-ported word bank.
// Optional macro LANE_VRF_WRITE_BYPASS_EN enables byte-merge forwarding to reads.
module lane_vrf_write_port #(
    parameter int ENTRIES      = 32,
    parameter int DATA_W       = 32,
    parameter int IDX_W        = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       vrfWriteRequest_ready,
    input  logic                       vrfWriteRequest_valid,
    input  logic [$clog2(ENTRIES)-1:0] vrfWriteRequest_bits_vd,
    input  logic [DATA_W/8-1:0]        vrfWriteRequest_bits_mask,
    input  logic [DATA_W-1:0]          vrfWriteRequest_bits_data,
    input  logic                       vrfWriteRequest_bits_last,
    input  logic [IDX_W-1:0]           vrfWriteRequest_bits_instructionIndex,
    input  logic                       readRequest_valid,
    output logic                       readRequest_ready,
    input  logic [$clog2(ENTRIES)-1:0] readRequest_bits_vd,
    output logic                       readResult_valid,
    output logic [DATA_W-1:0]          readResult_bits,
    output logic                       writeDone_valid,
    output logic [IDX_W-1:0]           writeDone_bits_instructionIndex,
    output logic [(1<<IDX_W)-1:0]      instructionWriting
);

    localparam int VD_W   = $clog2(ENTRIES);
    localparam int MASK_W = DATA_W / 8;
    localparam int NI     = 1 << IDX_W;
    localparam int SW     = $clog2(STARVE_LIMIT + 1);

    logic              w_valid_q;
    logic [VD_W-1:0]   w_vd_q;
    logic [MASK_W-1:0] w_mask_q;
    logic [DATA_W-1:0] w_data_q;
    logic              w_last_q;
    logic [IDX_W-1:0]  w_idx_q;

    logic [SW-1:0]     s_q;
    logic [SW-1:0]     s_d;

    logic [DATA_W-1:0] bank_q [ENTRIES];

    logic              read_acc;
    logic              commit;
    logic              starved;
    logic              accept;
    logic [DATA_W-1:0] rd_data_d;

    // Arbitration: reads win the bank port unless the pending write has starved
    always_comb begin
        starved           = (s_q == SW'(STARVE_LIMIT));
`ifdef LANE_VRF_WRITE_BYPASS_EN
        readRequest_ready = !starved;
`else
        readRequest_ready = !starved &&
                            !(w_valid_q && (w_vd_q == readRequest_bits_vd));
`endif
        read_acc              = readRequest_valid && readRequest_ready;
        commit                = w_valid_q && !read_acc;
        vrfWriteRequest_ready = !w_valid_q || commit;
        accept                = vrfWriteRequest_valid && vrfWriteRequest_ready;
        instructionWriting    = w_valid_q ? (NI'(1) << w_idx_q) : '0;
    end

    // Read data path: bank word, optionally merged with the pending write bytes
    always_comb begin
        rd_data_d = bank_q[readRequest_bits_vd];
`ifdef LANE_VRF_WRITE_BYPASS_EN
        for (int b = 0; b < MASK_W; b++) begin
            if (w_valid_q && (w_vd_q == readRequest_bits_vd) && w_mask_q[b]) begin
                rd_data_d[8*b +: 8] = w_data_q[8*b +: 8];
            end
        end
`endif
    end

    // Starvation counter next state: count blocked cycles, clear on commit/empty
    always_comb begin
        s_d = s_q;
        if (!w_valid_q || commit) begin
            s_d = '0;
        end else if (s_q != SW'(STARVE_LIMIT)) begin
            s_d = s_q + 1'b1;
        end
    end

    // Pending write register and starvation counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_valid_q <= 1'b0;
            w_vd_q    <= '0;
            w_mask_q  <= '0;
            w_data_q  <= '0;
            w_last_q  <= 1'b0;
            w_idx_q   <= '0;
            s_q       <= '0;
        end else begin
            s_q <= s_d;
            if (accept) begin
                w_valid_q <= 1'b1;
                w_vd_q    <= vrfWriteRequest_bits_vd;
                w_mask_q  <= vrfWriteRequest_bits_mask;
                w_data_q  <= vrfWriteRequest_bits_data;
                w_last_q  <= vrfWriteRequest_bits_last;
                w_idx_q   <= vrfWriteRequest_bits_instructionIndex;
            end else if (commit) begin
                w_valid_q <= 1'b0;
            end
        end
    end

    // Bank storage with byte-masked commit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bank_q[i] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (w_mask_q[b]) begin
                    bank_q[w_vd_q][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    // Registered read result and completion pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readResult_valid                <= 1'b0;
            readResult_bits                 <= '0;
            writeDone_valid                 <= 1'b0;
            writeDone_bits_instructionIndex <= '0;
        end else begin
            readResult_valid <= read_acc;
            if (read_acc) begin
                readResult_bits <= rd_data_d;
            end
            writeDone_valid <= commit && w_last_q;
            if (commit && w_last_q) begin
                writeDone_bits_instructionIndex <= w_idx_q;
            end
        end
    end

endmodule

// File: tb/tb_lane_vrf_write_port.sv
// Directed self-checking bench for lane_vrf_write_port.
// Forwarding expectations follow LANE_VRF_WRITE_BYPASS_EN when defined.
module tb_lane_vrf_write_port;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_ready;
    logic        wr_valid = 1'b0;
    logic [4:0]  wr_vd = '0;
    logic [3:0]  wr_mask = '0;
    logic [31:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [4:0]  rd_vd = '0;
    logic        res_valid;
    logic [31:0] res_bits;
    logic        done_valid;
    logic [2:0]  done_idx;
    logic [7:0]  iw;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    lane_vrf_write_port dut (
        .clock                                (clock),
        .reset                                (reset),
        .vrfWriteRequest_ready                (wr_ready),
        .vrfWriteRequest_valid                (wr_valid),
        .vrfWriteRequest_bits_vd              (wr_vd),
        .vrfWriteRequest_bits_mask            (wr_mask),
        .vrfWriteRequest_bits_data            (wr_data),
        .vrfWriteRequest_bits_last            (wr_last),
        .vrfWriteRequest_bits_instructionIndex(wr_idx),
        .readRequest_valid                    (rd_valid),
        .readRequest_ready                    (rd_ready),
        .readRequest_bits_vd                  (rd_vd),
        .readResult_valid                     (res_valid),
        .readResult_bits                      (res_bits),
        .writeDone_valid                      (done_valid),
        .writeDone_bits_instructionIndex      (done_idx),
        .instructionWriting                   (iw)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present_write(input logic [4:0] vd, input logic [3:0] m,
                                 input logic [31:0] d, input logic l,
                                 input logic [2:0] ix);
        wr_valid = 1'b1;
        wr_vd    = vd;
        wr_mask  = m;
        wr_data  = d;
        wr_last  = l;
        wr_idx   = ix;
    endtask

    // Issues a read with the bank idle and returns the registered result.
    task automatic do_read(input logic [4:0] vd, output logic v,
                           output logic [31:0] d);
        rd_valid = 1'b1;
        rd_vd    = vd;
        tick();
        rd_valid = 1'b0;
        #1;
        v = res_valid;
        d = res_bits;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_wr_ready got=%b exp=1", wr_ready);
        end
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_rd_ready got=%b exp=1", rd_ready);
        end
        checks++;
        if (iw !== 8'h00) begin
            failures++;
            $display("FAIL reset_iw got=%h exp=00", iw);
        end
        checks++;
        if ({res_valid, res_bits, done_valid, done_idx} !== 37'd0) begin
            failures++;
            $display("FAIL reset_regs got=%b/%h/%b/%0d exp=0",
                     res_valid, res_bits, done_valid, done_idx);
        end
    endtask

    task automatic test_write_basic();
        logic        v;
        logic [31:0] d;
        tick();
        present_write(5'd3, 4'hF, 32'hDEADBEEF, 1'b1, 3'd5);
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_accept_ready got=%b exp=1", wr_ready);
        end
        tick();
        wr_valid = 1'b0;
        #1;
        checks++;
        if (iw !== 8'h20 || done_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_pending iw=%h done=%b exp=20/0", iw, done_valid);
        end
        tick();
        checks++;
        if (iw !== 8'h00 || done_valid !== 1'b1 || done_idx !== 3'd5) begin
            failures++;
            $display("FAIL basic_done iw=%h done=%b idx=%0d exp=00/1/5",
                     iw, done_valid, done_idx);
        end
        tick();
        checks++;
        if (done_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got=%b exp=0", done_valid);
        end
        do_read(5'd3, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL basic_read v=%b d=%h exp=1/deadbeef", v, d);
        end
        #1;
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_res_not_held got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_byte_mask();
        logic        v;
        logic [31:0] d;
        present_write(5'd7, 4'hF, 32'h11223344, 1'b0, 3'd1);
        tick();
        wr_valid = 1'b0;
        tick();
        present_write(5'd7, 4'b0101, 32'hAABBCCDD, 1'b0, 3'd1);
        tick();
        wr_valid = 1'b0;
        tick();
        do_read(5'd7, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL mask_merge v=%b d=%h exp=1/11bb33dd", v, d);
        end
        #1;
        tick();
        present_write(5'd7, 4'b0000, 32'hFFFFFFFF, 1'b1, 3'd4);
        tick();
        wr_valid = 1'b0;
        tick();
        checks++;
        if (done_valid !== 1'b1 || done_idx !== 3'd4) begin
            failures++;
            $display("FAIL mask_zero_done done=%b idx=%0d exp=1/4", done_valid, done_idx);
        end
        do_read(5'd7, v, d);
        checks++;
        if (d !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL mask_zero_data got=%h exp=11bb33dd", d);
        end
        #1;
        tick();
    endtask

    task automatic test_starvation();
        logic        v;
        logic [31:0] d;
        present_write(5'd9, 4'hF, 32'h12345678, 1'b0, 3'd1);
        tick();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_vd    = 5'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (rd_ready !== 1'b1 || wr_ready !== 1'b0 || iw !== 8'h02) begin
                failures++;
                $display("FAIL starve_blocked_%0d rd_rdy=%b wr_rdy=%b iw=%h exp=1/0/02",
                         k, rd_ready, wr_ready, iw);
            end
            tick();
        end
        #1;
        checks++;
        if (rd_ready !== 1'b0 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL starve_forced rd_rdy=%b wr_rdy=%b exp=0/1", rd_ready, wr_ready);
        end
        tick();
        checks++;
        if (rd_ready !== 1'b1 || iw !== 8'h00 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL starve_after rd_rdy=%b iw=%h resv=%b exp=1/00/0",
                     rd_ready, iw, res_valid);
        end
        rd_valid = 1'b0;
        tick();
        do_read(5'd9, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h12345678) begin
            failures++;
            $display("FAIL starve_commit_data v=%b d=%h exp=1/12345678", v, d);
        end
        #1;
        tick();
    endtask

    task automatic test_forward();
        present_write(5'd2, 4'hF, 32'hCAFEF00D, 1'b0, 3'd2);
        tick();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_vd    = 5'd2;
        #1;
`ifdef LANE_VRF_WRITE_BYPASS_EN
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL fwd_rd_ready got=%b exp=1", rd_ready);
        end
`else
        checks++;
        if (rd_ready !== 1'b0) begin
            failures++;
            $display("FAIL fwd_rd_blocked got=%b exp=0", rd_ready);
        end
        tick();
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL fwd_rd_ready got=%b exp=1", rd_ready);
        end
`endif
        tick();
        rd_valid = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_bits !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL fwd_data v=%b d=%h exp=1/cafef00d", res_valid, res_bits);
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int          pulses = 0;
        logic        v;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            present_write(5'(10 + i), 4'hF, 32'hB0B0_0000 + i, i == 7, 3'd3);
            #1;
            checks++;
            if (wr_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_%0d got=%b exp=1", i, wr_ready);
            end
            tick();
            if (done_valid === 1'b1) pulses++;
        end
        wr_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (done_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL b2b_done_pulses got=%0d exp=1", pulses);
        end
        do_read(5'd10, v, d);
        checks++;
        if (d !== 32'hB0B0_0000) begin
            failures++;
            $display("FAIL b2b_first_word got=%h exp=b0b00000", d);
        end
        #1;
        do_read(5'd17, v, d);
        checks++;
        if (d !== 32'hB0B0_0007) begin
            failures++;
            $display("FAIL b2b_last_word got=%h exp=b0b00007", d);
        end
        #1;
        tick();
    endtask

    task automatic test_reset_mid();
        int          pulses = 0;
        logic        v;
        logic [31:0] d;
        present_write(5'd5, 4'hF, 32'h55555555, 1'b1, 3'd6);
        tick();
        wr_valid = 1'b0;
        checks++;
        if (iw !== 8'h40) begin
            failures++;
            $display("FAIL rstmid_pending got=%h exp=40", iw);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (iw !== 8'h00 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_iw iw=%h wr_rdy=%b exp=00/1", iw, wr_ready);
        end
        tick();
        if (done_valid === 1'b1) pulses++;
        @(negedge clock);
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (done_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL rstmid_no_done got=%0d exp=0", pulses);
        end
        do_read(5'd5, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_read5 v=%b d=%h exp=1/0", v, d);
        end
        #1;
        do_read(5'd7, v, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_read7 got=%h exp=0", d);
        end
        #1;
        do_read(5'd3, v, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_read3 got=%h exp=0", d);
        end
        #1;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_byte_mask();
        test_starvation();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_vrf_write_port.md
# lane_vrf_write_port

Receiving end of the lane stage-3 VRF write interface. Accepts masked 32-bit write requests (vd, byte mask, data, last, instructionIndex) through a ready/valid handshake and commits them into a single-ported, per-lane register bank. The bank also serves a read port. The block arbitrates between the read port and pending writes, forwards pending writes to reads, and reports per-instruction write completion to the lane's instruction tracking logic.

## Interface
Parameters:
- ENTRIES, 32: bank depth (one 32-bit word per vd); vd width is log2(ENTRIES)=5
- DATA_W, 32: word width; MASK_W = DATA_W/8 = 4 byte enables
- IDX_W, 3: instructionIndex width
- STARVE_LIMIT, 4: consecutive cycles a pending write may be blocked by reads before reads are throttled

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- vrfWriteRequest_ready  out  1  write request accepted this cycle when high with valid
- vrfWriteRequest_valid  in  1  write request present
- vrfWriteRequest_bits_vd  in  5  target word
- vrfWriteRequest_bits_mask  in  4  byte enables; bit i covers data[8i+7:8i]
- vrfWriteRequest_bits_data  in  32  write data
- vrfWriteRequest_bits_last  in  1  final write of the instruction
- vrfWriteRequest_bits_instructionIndex  in  3  owning instruction slot
- readRequest_valid  in  1  read request
- readRequest_ready  out  1  read accepted when high with valid
- readRequest_bits_vd  in  5  word to read
- readResult_valid  out  1  read data valid, one cycle after acceptance
- readResult_bits  out  32  read data
- writeDone_valid  out  1  one-cycle pulse: a last write was committed
- writeDone_bits_instructionIndex  out  3  slot of the completed instruction
- instructionWriting  out  8  one-hot of the pending write's instructionIndex; 0 when none is pending

## Operation
- Pending register W: one entry holding valid, vd, mask, data, last and index. `vrfWriteRequest_ready = !W.valid || commit`. An accept loads W, so a commit and an accept can occur in the same cycle.
- Bank: ENTRIES×DATA_W flops with byte-masked write. Mask 0 is legal: it commits, writes nothing and still signals last.
- Arbitration each cycle (single bank port):
  - A read is accepted when `readRequest_valid && readRequest_ready`.
  - `commit = W.valid && !read_accepted`. Reads have priority.
- Starvation counter S (saturating, width ceil(log2(STARVE_LIMIT+1))):
  - Increments each cycle W.valid is held and not committed.
  - Clears on commit or when W is empty.
  - When S == STARVE_LIMIT, `readRequest_ready = 0`, so W commits that cycle.
- Read data: bank[vd] sampled before this cycle's commit, merged per byte with W.data where W.valid, W.vd == read vd and W.mask bit is set (bypass). Registered into readResult_bits.
- Completion: a commit with W.last=1 drives writeDone_valid=1 on the next cycle with W's index. Otherwise writeDone_valid=0.
- instructionWriting = W.valid ? (1 << W.index) : 0.

## Timing
- Reset (async assert, sync deassert externally) drives:
  - W.valid=0, S=0, all bank words 0
  - readResult_valid=0, readResult_bits=0, writeDone_valid=0, writeDone_bits_instructionIndex=0
  - outputs after reset: vrfWriteRequest_ready=1, readRequest_ready=1, instructionWriting=0
- Write: accepted at edge t, earliest commit at edge t+1, visible in bank after t+1. With no reads, throughput is one write per cycle.
- Read: accepted at edge t; readResult_valid=1 and data stable during cycle t+1. readResult_valid is not held; there is no back-pressure on results.
- A write accepted at t and a read issued in cycle t+1 to the same vd return the merged (new) data.
- Worst-case write stall with continuous reads: STARVE_LIMIT cycles, then a forced commit.
- Reset asserted mid-operation drops W without a writeDone pulse and clears the bank.

## Configuration
- LANE_VRF_WRITE_BYPASS_EN defined: byte-merge forwarding as described above.
- Not defined: no merge path. `readRequest_ready` is forced to 0 while W.valid and W.vd == readRequest_bits_vd, so W commits first and the read then returns bank data. The starvation rule still applies to all other vd values.

## Test plan
- Reset, then write vd=3 mask=4'hF data=32'hDEADBEEF last=1 idx=5, no reads. Expect ready=1 at accept, instructionWriting=8'h20 for 1 cycle, writeDone_valid=1 idx=5 one cycle after commit, and a later read of vd=3 returning 32'hDEADBEEF.
- Bank vd=7 = 32'h11223344; write mask=4'b0101 data=32'hAABBCCDD. Expect a read of vd=7 to return 32'h11BB33DD.
- Continuous readRequest_valid on vd=0 with a write pending to vd=9. Expect readRequest_ready to drop for exactly 1 cycle after 4 blocked cycles, the write to commit in that cycle, and vrfWriteRequest_ready=1 in the same cycle.
- Write vd=2 data=32'hCAFEF00D, then a read of vd=2 in the next cycle while W is still pending. With the macro: the read is accepted and returns 32'hCAFEF00D. Without the macro: readRequest_ready=0 for 1 cycle, then the read returns 32'hCAFEF00D.
- Back-to-back writes, 8 cycles with valid always high, no reads, last only on the final write. Expect ready always 1, 8 commits, and a single writeDone pulse.
- Assert reset while W holds last=1. Expect no writeDone pulse, instructionWriting=0 immediately, and all reads returning 0 afterwards.
